// File: rtl/serial_tx_if.sv
// Word handshake into the serial transmitter: producer drives valid/data,
// transmitter answers with ready.
`timescale 1ns/1ps

interface serial_tx_if #(
  parameter int DATA_W = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;

  modport master (
    output in_valid,
    output in_data,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_data,
    output in_ready
  );
endinterface

// File: rtl/serial_tx.sv
// Serial frame transmitter: start bit (0), DATA_W data bits LSB first, stop bit (1),
// each bit held CLKS_PER_BIT clocks; the line output comes straight from a flop.
//
// state | meaning
// IDLE  | line high, ready for a word; tx_done is high here for one cycle after STOP
// START | line low for one bit period
// DATA  | shifting out payload bits, LSB first
// STOP  | line high for one bit period
`timescale 1ns/1ps

module serial_tx #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4
) (
  input  logic        aclk,
  input  logic        arst,
  serial_tx_if.slave  in_if,
  output logic        tx,
  output logic        busy,
  output logic        tx_done
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [DATA_W-1:0] shreg_shift;
  logic              tx_q, tx_d;
  logic              done_q, done_d;
  logic              bit_end;
  logic              accept;

  assign bit_end        = (cnt_q == CNT_LAST);
  assign accept         = in_if.in_valid && (state_q == S_IDLE);
  assign shreg_shift    = shreg_q >> 1;

  assign in_if.in_ready = (state_q == S_IDLE);
  assign busy           = (state_q != S_IDLE);
  assign tx             = tx_q;
  assign tx_done        = done_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shreg_d = shreg_q;
    tx_d    = tx_q;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if (accept) begin
          state_d = S_START;
          shreg_d = in_if.in_data;
          cnt_d   = '0;
          idx_d   = '0;
          tx_d    = 1'b0;
        end
      end

      S_START: begin
        if (bit_end) begin
          cnt_d   = '0;
          state_d = S_DATA;
          tx_d    = shreg_q[0];
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_DATA: begin
        if (bit_end) begin
          cnt_d = '0;
          if (idx_q == IDX_LAST) begin
            state_d = S_STOP;
            idx_d   = '0;
            tx_d    = 1'b1;
          end else begin
            // next bit is loaded into the line flop together with the shift
            idx_d   = idx_q + IDX_W'(1);
            shreg_d = shreg_shift;
            tx_d    = shreg_shift[0];
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_STOP: begin
        tx_d = 1'b1;
        if (bit_end) begin
          cnt_d   = '0;
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        idx_d   = '0;
        tx_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge aclk or posedge arst) begin
    if (arst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shreg_q <= '0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shreg_q <= shreg_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_serial_tx.sv
// Bench for serial_tx: per-cycle scoreboard of tx/tx_done/in_ready/busy for the
// 8-bit, 4-clock instance, plus a 1-bit, 1-clock instance.
`timescale 1ns/1ps

module tb_serial_tx;

  localparam int DW  = 8;
  localparam int CPB = 4;

  logic aclk = 1'b0;
  logic arst = 1'b1;
  logic tx, busy, tx_done;
  logic tx1, busy1, tx_done1;

  serial_tx_if #(.DATA_W(DW)) bus ();
  serial_tx_if #(.DATA_W(1))  bus1 ();

  serial_tx #(.DATA_W(DW), .CLKS_PER_BIT(CPB)) dut (
    .aclk    (aclk),
    .arst    (arst),
    .in_if   (bus),
    .tx      (tx),
    .busy    (busy),
    .tx_done (tx_done)
  );

  serial_tx #(.DATA_W(1), .CLKS_PER_BIT(1)) dut1 (
    .aclk    (aclk),
    .arst    (arst),
    .in_if   (bus1),
    .tx      (tx1),
    .busy    (busy1),
    .tx_done (tx_done1)
  );

  always #5 aclk = ~aclk;

  typedef struct packed {
    logic tx;
    logic done;
    logic rdy;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // expected line/status for every cycle after the handshake, ending with the tx_done cycle
  function automatic void push_frame(input logic [DW-1:0] w);
    for (int c = 0; c < CPB; c++) exp_q.push_back(exp_t'{tx: 1'b0, done: 1'b0, rdy: 1'b0});
    for (int b = 0; b < DW; b++)
      for (int c = 0; c < CPB; c++) exp_q.push_back(exp_t'{tx: w[b], done: 1'b0, rdy: 1'b0});
    for (int c = 0; c < CPB; c++) exp_q.push_back(exp_t'{tx: 1'b1, done: 1'b0, rdy: 1'b0});
    exp_q.push_back(exp_t'{tx: 1'b1, done: 1'b1, rdy: 1'b1});
  endfunction

  task automatic tick();
    exp_t e;
    @(negedge aclk);
    if (!arst) begin
      if (exp_q.size() > 0) e = exp_q.pop_front();
      else e = exp_t'{tx: 1'b1, done: 1'b0, rdy: 1'b1};
      n_tests++;
      if (tx !== e.tx || tx_done !== e.done || bus.in_ready !== e.rdy || busy !== ~e.rdy) begin
        n_fail++;
        $display("FAIL sb_cycle @%0t got tx=%b done=%b rdy=%b busy=%b, want tx=%b done=%b rdy=%b busy=%b",
                 $time, tx, tx_done, bus.in_ready, busy, e.tx, e.done, e.rdy, ~e.rdy);
      end
    end
  endtask

  task automatic send_word(input logic [DW-1:0] w);
    bus.in_valid = 1'b1;
    bus.in_data  = w;
    push_frame(w);
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200 && exp_q.size() > 0; i++) tick();
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL wait_idle timeout, %0d expected cycles left, want 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    #100;
    n_tests++;
    if (tx !== 1'b1 || busy !== 1'b0 || tx_done !== 1'b0 || bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_hold got tx=%b busy=%b done=%b rdy=%b, want 1 0 0 1", tx, busy, tx_done, bus.in_ready);
    end
    n_tests++;
    if (tx1 !== 1'b1 || busy1 !== 1'b0 || tx_done1 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_hold_w1 got tx=%b busy=%b done=%b, want 1 0 0", tx1, busy1, tx_done1);
    end
    // word presented during reset, handshake expected on the very first edge after release
    @(negedge aclk);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hC3;
    arst = 1'b0;
    #1;
    n_tests++;
    if (bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release_ready got %b want 1", bus.in_ready);
    end
    push_frame(8'hC3);
    tick();
    bus.in_valid = 1'b0;
    wait_idle();
  endtask

  task automatic test_single();
    int busy_cnt = 0;
    int done_cnt = 0;
    tick();
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hA5;
    push_frame(8'hA5);
    for (int k = 0; k < 41; k++) begin
      tick();
      if (k == 0) bus.in_valid = 1'b0;
      if (busy === 1'b1) busy_cnt++;
      if (tx_done === 1'b1) done_cnt++;
    end
    n_tests++;
    if (busy_cnt != 40) begin
      n_fail++;
      $display("FAIL single_busy_cycles got %0d want 40", busy_cnt);
    end
    n_tests++;
    if (done_cnt != 1) begin
      n_fail++;
      $display("FAIL single_done_pulses got %0d want 1", done_cnt);
    end
  endtask

  task automatic test_back_to_back();
    tick();
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h00;
    push_frame(8'h00);
    tick();
    bus.in_data = 8'hFF;
    repeat (40) tick();
    n_tests++;
    if (tx_done !== 1'b1 || bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_handshake_on_done got done=%b rdy=%b want 1 1", tx_done, bus.in_ready);
    end
    push_frame(8'hFF);
    tick();
    bus.in_valid = 1'b0;
    wait_idle();
  endtask

  task automatic test_busy_immunity();
    int         extra_hs = 0;
    logic [7:0] word     = 8'h00;
    tick();
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h3C;
    push_frame(8'h3C);
    for (int c = 1; c <= 40; c++) begin
      tick();
      if (c >= 6 && c <= 34 && ((c - 6) % 4) == 0) word[(c - 6) / 4] = tx;
      if (bus.in_valid === 1'b1 && bus.in_ready === 1'b1) extra_hs++;
      if (c < 40) begin
        bus.in_data  = 8'($urandom);
        bus.in_valid = 1'b1;
      end else begin
        bus.in_valid = 1'b0;
      end
    end
    tick();
    n_tests++;
    if (word !== 8'h3C) begin
      n_fail++;
      $display("FAIL immunity_word got %h want 3c", word);
    end
    n_tests++;
    if (extra_hs != 0) begin
      n_fail++;
      $display("FAIL immunity_handshakes got %0d want 1", 1 + extra_hs);
    end
  endtask

  task automatic test_reset_midframe();
    tick();
    send_word(8'h81);
    repeat (15) tick();
    @(posedge aclk);
    #2;
    n_tests++;
    if (tx !== 1'b0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL midframe_pre got tx=%b busy=%b want 0 1", tx, busy);
    end
    arst = 1'b1;
    exp_q.delete();
    #1;
    n_tests++;
    if (tx !== 1'b1 || busy !== 1'b0 || bus.in_ready !== 1'b1 || tx_done !== 1'b0) begin
      n_fail++;
      $display("FAIL midframe_async got tx=%b busy=%b rdy=%b done=%b want 1 0 1 0", tx, busy, bus.in_ready, tx_done);
    end
    tick();
    tick();
    arst = 1'b0;
    tick();
    tick();
    send_word(8'h55);
    wait_idle();
  endtask

  task automatic test_clks1();
    logic [2:0] exp1[$];
    logic [2:0] e;
    // {tx, tx_done, busy} per cycle after the handshake
    exp1.push_back(3'b001);
    exp1.push_back(3'b101);
    exp1.push_back(3'b101);
    exp1.push_back(3'b110);
    exp1.push_back(3'b100);
    tick();
    bus1.in_valid = 1'b1;
    bus1.in_data  = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (k == 0) bus1.in_valid = 1'b0;
      e = exp1.pop_front();
      n_tests++;
      if ({tx1, tx_done1, busy1} !== e) begin
        n_fail++;
        $display("FAIL w1_cycle%0d got tx=%b done=%b busy=%b want tx=%b done=%b busy=%b",
                 k + 1, tx1, tx_done1, busy1, e[2], e[1], e[0]);
      end
    end
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus1.in_valid = 1'b0;
    bus1.in_data  = '0;
    test_reset();
    test_single();
    test_back_to_back();
    test_busy_immunity();
    test_reset_midframe();
    test_clks1();
    tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
